// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the IF and MEM pipeline stages.
// Data accesses have priority, and a starvation counter forces a fetch through after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                dm_read,
  input  logic                dm_write,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             dm_req;
  logic             if_elig;
  logic             dm_elig;
  logic             starved;
  logic             grant_if;
  logic             grant_dm;

  assign dm_req  = dm_read | dm_write;
  // A requester whose ack is high this cycle is still showing its old request.
  assign if_elig = if_req & ~if_ack;
  assign dm_elig = dm_req & ~dm_ack;
  assign starved = (starve_cnt == CNT_MAX);

  assign grant_if = (state == IDLE) & if_elig & (~dm_elig | starved);
  assign grant_dm = (state == IDLE) & dm_elig & ~grant_if;

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = dm_req & ~dm_ack;
  assign busy      = (state != IDLE);

  always_comb begin
    // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_if)      state_nxt = FETCH;
        else if (grant_dm) state_nxt = DATA;
      end
      FETCH, DATA: begin
        if (mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_if) begin
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_be     <= '1;
            starve_cnt <= '0;
          end else if (grant_dm) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_write;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_be;
            if (if_elig && !starved) starve_cnt <= starve_cnt + 1'b1;
          end
        end
        FETCH: begin
          if (mem_ready) begin
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_ack   <= 1'b1;
          end
        end
        DATA: begin
          if (mem_ready) begin
            mem_req  <= 1'b0;
            dm_rdata <= mem_we ? '0 : mem_rdata;
            dm_ack   <= 1'b1;
          end
        end
        default: mem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table followed by a starvation sequence.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        rst;
    bit        ifr;
    bit [31:0] ifa;
    bit        dr;
    bit        dw;
    bit [31:0] da;
    bit [31:0] dwd;
    bit [3:0]  dbe;
    bit [31:0] mrd;
    bit        mrdy;
  } in_t;

  typedef struct {
    bit        req;
    bit        we;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [3:0]  be;
    bit        chk_mem;
    bit        iack;
    bit        dack;
    bit [31:0] irdata;
    bit [31:0] drdata;
    bit        sif;
    bit        smem;
    bit        busy;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply(input in_t v);
    reset     = v.rst;
    if_req    = v.ifr;
    if_addr   = v.ifa;
    dm_read   = v.dr;
    dm_write  = v.dw;
    dm_addr   = v.da;
    dm_wdata  = v.dwd;
    dm_be     = v.dbe;
    mem_rdata = v.mrd;
    mem_ready = v.mrdy;
  endtask

  initial begin
    // Each row is one clock cycle: inputs driven during it and the outputs expected in it.
    // reset
    vecs[0]  = '{'{1,0,0,0,0,0,0,0,0,0},                             '{0,0,0,0,0,1,0,0,0,0,0,0,0}};
    // single fetch at 0x100
    vecs[1]  = '{'{0,1,'h100,0,0,0,0,0,'h00500093,1},                '{0,0,0,0,0,1,0,0,0,0,1,0,0}};
    vecs[2]  = '{'{0,1,'h100,0,0,0,0,0,'h00500093,1},                '{1,0,'h100,0,'hF,1,0,0,0,0,1,0,1}};
    vecs[3]  = '{'{0,1,'h100,0,0,0,0,0,'h00500093,1},                '{0,0,0,0,0,0,1,0,'h00500093,0,0,0,0}};
    vecs[4]  = '{'{0,0,0,0,0,0,0,0,0,1},                             '{0,0,0,0,0,0,0,0,'h00500093,0,0,0,0}};
    // simultaneous fetch and data read: data first, fetch in the dm_ack cycle
    vecs[5]  = '{'{0,1,'h200,1,0,'h2000,0,0,'h11111111,1},           '{0,0,0,0,0,0,0,0,'h00500093,0,1,1,0}};
    vecs[6]  = '{'{0,1,'h200,1,0,'h2000,0,0,'h11111111,1},           '{1,0,'h2000,0,0,1,0,0,'h00500093,0,1,1,1}};
    vecs[7]  = '{'{0,1,'h200,1,0,'h2000,0,0,'h22222222,1},           '{0,0,0,0,0,0,0,1,'h00500093,'h11111111,1,0,0}};
    vecs[8]  = '{'{0,1,'h200,0,0,0,0,0,'h22222222,1},                '{1,0,'h200,0,'hF,1,0,0,'h00500093,'h11111111,1,0,1}};
    vecs[9]  = '{'{0,0,0,0,0,0,0,0,0,1},                             '{0,0,0,0,0,0,1,0,'h22222222,'h11111111,0,0,0}};
    // read and write both high: write, dm_rdata cleared
    vecs[10] = '{'{0,0,0,1,1,'h80,'h12345678,'hF,'h44444444,1},      '{0,0,0,0,0,0,0,0,'h22222222,'h11111111,0,1,0}};
    vecs[11] = '{'{0,0,0,0,0,0,0,0,'h44444444,1},                    '{1,1,'h80,'h12345678,'hF,1,0,0,'h22222222,'h11111111,0,0,1}};
    vecs[12] = '{'{0,0,0,0,0,0,0,0,0,1},                             '{0,0,0,0,0,0,0,1,'h22222222,0,0,0,0}};
    // plain read loads dm_rdata
    vecs[13] = '{'{0,0,0,1,0,'h3000,0,0,'h55555555,1},               '{0,0,0,0,0,0,0,0,'h22222222,0,0,1,0}};
    vecs[14] = '{'{0,0,0,0,0,0,0,0,'h55555555,1},                    '{1,0,'h3000,0,0,1,0,0,'h22222222,0,0,0,1}};
    // write request in the ack cycle is stale and not granted
    vecs[15] = '{'{0,0,0,0,1,'h40,'hDEADBEEF,'h3,0,0},               '{0,0,0,0,0,0,0,1,'h22222222,'h55555555,0,0,0}};
    // write with three wait states; inputs change after grant
    vecs[16] = '{'{0,0,0,0,1,'h40,'hDEADBEEF,'h3,0,0},               '{0,0,0,0,0,0,0,0,'h22222222,'h55555555,0,1,0}};
    vecs[17] = '{'{0,0,0,0,1,'h999,0,0,0,0},                         '{1,1,'h40,'hDEADBEEF,'h3,1,0,0,'h22222222,'h55555555,0,1,1}};
    vecs[18] = '{'{0,0,0,0,1,'h999,0,0,0,0},                         '{1,1,'h40,'hDEADBEEF,'h3,1,0,0,'h22222222,'h55555555,0,1,1}};
    vecs[19] = '{'{0,0,0,0,1,'h999,0,0,0,0},                         '{1,1,'h40,'hDEADBEEF,'h3,1,0,0,'h22222222,'h55555555,0,1,1}};
    vecs[20] = '{'{0,0,0,0,1,'h999,0,0,'h66666666,1},                '{1,1,'h40,'hDEADBEEF,'h3,1,0,0,'h22222222,'h55555555,0,1,1}};
    vecs[21] = '{'{0,0,0,0,1,'h999,0,0,'h66666666,1},                '{0,0,0,0,0,0,0,1,'h22222222,0,0,0,0}};
    vecs[22] = '{'{0,0,0,0,0,0,0,0,'h66666666,1},                    '{0,0,0,0,0,0,0,0,'h22222222,0,0,0,0}};
    // reset in the middle of a data read
    vecs[23] = '{'{0,0,0,1,0,'h500,0,0,0,0},                         '{0,0,0,0,0,0,0,0,'h22222222,0,0,1,0}};
    vecs[24] = '{'{0,0,0,1,0,'h500,0,0,0,0},                         '{1,0,'h500,0,0,1,0,0,'h22222222,0,0,1,1}};
    vecs[25] = '{'{1,0,0,1,0,'h500,0,0,0,0},                         '{1,0,'h500,0,0,1,0,0,'h22222222,0,0,1,1}};
    vecs[26] = '{'{0,0,0,0,0,0,0,0,'h77777777,1},                    '{0,0,0,0,0,1,0,0,0,0,0,0,0}};
    vecs[27] = '{'{0,0,0,0,0,0,0,0,'h77777777,1},                    '{0,0,0,0,0,1,0,0,0,0,0,0,0}};
  end

  initial begin : main
    bit exp_we[11];
    int ng;
    bit prev_req;

    apply(vecs[0].i);
    repeat (2) @(posedge clk);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      apply(vecs[i].i);
      #1;
      check($sformatf("v%0d_mem_req", i),   32'(mem_req),   32'(vecs[i].o.req));
      check($sformatf("v%0d_if_ack", i),    32'(if_ack),    32'(vecs[i].o.iack));
      check($sformatf("v%0d_dm_ack", i),    32'(dm_ack),    32'(vecs[i].o.dack));
      check($sformatf("v%0d_if_rdata", i),  if_rdata,       vecs[i].o.irdata);
      check($sformatf("v%0d_dm_rdata", i),  dm_rdata,       vecs[i].o.drdata);
      check($sformatf("v%0d_stall_if", i),  32'(stall_if),  32'(vecs[i].o.sif));
      check($sformatf("v%0d_stall_mem", i), 32'(stall_mem), 32'(vecs[i].o.smem));
      check($sformatf("v%0d_busy", i),      32'(busy),      32'(vecs[i].o.busy));
      if (vecs[i].o.chk_mem) begin
        check($sformatf("v%0d_mem_we", i),    32'(mem_we),  32'(vecs[i].o.we));
        check($sformatf("v%0d_mem_addr", i),  mem_addr,     vecs[i].o.addr);
        check($sformatf("v%0d_mem_wdata", i), mem_wdata,    vecs[i].o.wdata);
        check($sformatf("v%0d_mem_be", i),    32'(mem_be),  32'(vecs[i].o.be));
      end
    end

    // Starvation: dm_write held, if_req dropped only in dm_ack cycles so each data
    // grant sees an eligible fetch. Expected grant order (1 = data write, 0 = fetch).
    exp_we = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
    ng = 0;
    prev_req = 1'b0;
    for (int cyc = 0; cyc < 200 && ng < 11; cyc++) begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        check($sformatf("starve_grant%0d_we", ng), 32'(mem_we), 32'(exp_we[ng]));
        ng++;
      end
      prev_req  = mem_req;
      reset     = 1'b0;
      dm_read   = 1'b0;
      dm_write  = 1'b1;
      dm_addr   = 32'h600;
      dm_wdata  = 32'hA5A5A5A5;
      dm_be     = 4'hF;
      if_addr   = 32'h700;
      mem_rdata = 32'h0;
      mem_ready = 1'b1;
      if_req    = ~dm_ack;
    end
    if (ng < 11) check("starve_timeout", 32'(ng), 32'd11);

    @(negedge clk);
    if_req   = 1'b0;
    dm_write = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
